// File: rtl/mimo_out_collector.sv
// rtl/mimo_out_collector.sv - K-best detector output capture, frame tagging and result FIFO (optional GRAY_DEMAP_EN)
module mimo_out_collector #(
    parameter int LAT   = 132,
    parameter int DEPTH = 8,
    parameter int IDXW  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     soft_clr,
    input  logic                     in_start,
    input  logic [15:0]              X,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [15:0]              out_sym,
    output logic [IDXW-1:0]          out_idx,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     ovf
);

    localparam int AW = $clog2(DEPTH);
    localparam int WW = IDXW + 16;

    logic [LAT-1:0]  dly;
    logic            strobe;
    logic [IDXW-1:0] idx_cnt;
    logic [AW:0]     wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n;
    logic [WW-1:0]   mem [DEPTH];
    logic [WW-1:0]   wdata, head_n;
    logic [15:0]     sym_map;
    logic            empty, full, pop, push, drop;

`ifdef GRAY_DEMAP_EN
    // Each 2-bit PAM index p becomes {p[1], p[1]^p[0]}
    function automatic logic [15:0] gray_map(input logic [15:0] x);
        logic [15:0] y;
        for (int i = 0; i < 8; i++) begin
            y[2*i+1] = x[2*i+1];
            y[2*i]   = x[2*i+1] ^ x[2*i];
        end
        return y;
    endfunction
    assign sym_map = gray_map(X);
`else
    assign sym_map = X;
`endif

    assign strobe    = dly[LAT-1];
    assign empty     = (wr_ptr == rd_ptr);
    assign full      = ((wr_ptr ^ rd_ptr) == {1'b1, {AW{1'b0}}});
    assign pop       = !empty && out_ready;
    assign push      = strobe && (!full || pop);
    assign drop      = strobe && full && !pop;
    assign wr_ptr_n  = wr_ptr + {{AW{1'b0}}, push};
    assign rd_ptr_n  = rd_ptr + {{AW{1'b0}}, pop};
    assign wdata     = {idx_cnt, sym_map};
    assign out_valid = !empty;
    assign count     = wr_ptr - rd_ptr;

    // Next head word: zero when the FIFO will be empty, the incoming word when it lands in an otherwise empty FIFO
    always_comb begin
        head_n = '0;
        if (wr_ptr_n != rd_ptr_n) begin
            if (push && (wr_ptr == rd_ptr_n)) begin
                head_n = wdata;
            end else begin
                head_n = mem[rd_ptr_n[AW-1:0]];
            end
        end
    end

    // Frame latency tracking, capture index, FIFO pointers, overflow flag and registered head
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dly     <= '0;
            idx_cnt <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            ovf     <= 1'b0;
            out_sym <= '0;
            out_idx <= '0;
        end else if (soft_clr) begin
            dly     <= '0;
            idx_cnt <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            ovf     <= 1'b0;
            out_sym <= '0;
            out_idx <= '0;
        end else begin
            dly    <= {dly[LAT-2:0], in_start};
            wr_ptr <= wr_ptr_n;
            rd_ptr <= rd_ptr_n;
            if (strobe) begin
                idx_cnt <= idx_cnt + IDXW'(1);
            end
            if (drop) begin
                ovf <= 1'b1;
            end
            {out_idx, out_sym} <= head_n;
        end
    end

    // FIFO storage needs no reset; pointers define what is valid
    always_ff @(posedge clk) begin
        if (push && !soft_clr) begin
            mem[wr_ptr[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: tb/tb_mimo_out_collector.sv
// tb/tb_mimo_out_collector.sv - directed self-checking bench for mimo_out_collector
module tb_mimo_out_collector;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        soft_clr = 1'b0;
    logic        in_start = 1'b0;
    logic [15:0] X = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_sym;
    logic [15:0] out_idx;
    logic [3:0]  count;
    logic        ovf;

    int errors = 0;
    int checks = 0;

    mimo_out_collector #(.LAT(132), .DEPTH(8), .IDXW(16)) dut (
        .clk(clk), .rst(rst), .soft_clr(soft_clr), .in_start(in_start), .X(X),
        .out_valid(out_valid), .out_ready(out_ready), .out_sym(out_sym),
        .out_idx(out_idx), .count(count), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // X pattern: constant per 10-cycle capture window, window k starting at cycle 132+10k
    function automatic logic [15:0] xv(int c);
        int k;
        k = (c < 132) ? 0 : (c - 132) / 10;
        return 16'h1357 ^ 16'(k * 'h1111);
    endfunction

    function automatic logic [15:0] exp_sym(logic [15:0] x);
        logic [15:0] y;
`ifdef GRAY_DEMAP_EN
        logic [1:0] lut [4];
        lut[0] = 2'b00; lut[1] = 2'b01; lut[2] = 2'b11; lut[3] = 2'b10;
        for (int i = 0; i < 8; i++) y[2*i +: 2] = lut[x[2*i +: 2]];
`else
        y = x;
`endif
        return y;
    endfunction

    task automatic do_reset();
        rst = 1'b0; soft_clr = 1'b0; in_start = 1'b0; out_ready = 1'b0; X = '0;
        tick(); tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        #2 rst = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", ovf); end
        checks++; if (out_sym !== 16'h0) begin errors++; $display("FAIL reset_sym: got %h want 0000", out_sym); end
        checks++; if (out_idx !== 16'h0) begin errors++; $display("FAIL reset_idx: got %h want 0000", out_idx); end
        do_reset();
    endtask

    task automatic test_single();
        int nv = 0;
        int first = -1;
        logic [15:0] s = '0;
        logic [15:0] ix = '1;
        logic [15:0] want;
`ifdef GRAY_DEMAP_EN
        want = 16'hF582;
`else
        want = 16'hA5C3;
`endif
        do_reset();
        out_ready = 1'b1; X = 16'hA5C3; in_start = 1'b1;
        for (int c = 0; c < 160; c++) begin
            if (out_valid) begin
                if (first < 0) begin first = c; s = out_sym; ix = out_idx; end
                nv++;
            end
            tick();
            in_start = 1'b0;
        end
        checks++; if (first != 133) begin errors++; $display("FAIL single_cycle: got %0d want 133", first); end
        checks++; if (nv != 1) begin errors++; $display("FAIL single_nvalid: got %0d want 1", nv); end
        checks++; if (s !== want) begin errors++; $display("FAIL single_sym: got %h want %h", s, want); end
        checks++; if (ix !== 16'd0) begin errors++; $display("FAIL single_idx: got %0d want 0", ix); end
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL single_count: got %0d want 0", count); end
    endtask

    task automatic test_stream();
        int n = 0;
        do_reset();
        out_ready = 1'b1;
        for (int c = 0; c < 400; c++) begin
            in_start = (c % 10 == 0) && (c < 200);
            X = xv(c);
            if (out_valid) begin
                checks++; if (out_idx !== 16'(n)) begin errors++; $display("FAIL stream_idx: got %0d want %0d", out_idx, n); end
                checks++; if (out_sym !== exp_sym(xv(132 + 10*n))) begin errors++; $display("FAIL stream_sym: got %h want %h", out_sym, exp_sym(xv(132 + 10*n))); end
                checks++; if (c != 10*n + 133) begin errors++; $display("FAIL stream_cycle: got %0d want %0d", c, 10*n + 133); end
                n++;
            end
            tick();
        end
        in_start = 1'b0;
        checks++; if (n != 20) begin errors++; $display("FAIL stream_count: got %0d want 20", n); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL stream_ovf: got %b want 0", ovf); end
    endtask

    task automatic test_overflow();
        int n = 0;
        int first = -1;
        do_reset();
        for (int c = 0; c < 230; c++) begin
            in_start = (c % 10 == 0) && (c < 100);
            X = xv(c);
            if (c == 212) begin
                checks++; if (count !== 4'd8) begin errors++; $display("FAIL ovf_sat_count: got %0d want 8", count); end
                checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_early: got %b want 0", ovf); end
                checks++; if (out_idx !== 16'd0) begin errors++; $display("FAIL ovf_head_stable: got %0d want 0", out_idx); end
            end
            if (c == 213) begin
                checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b want 1", ovf); end
                checks++; if (count !== 4'd8) begin errors++; $display("FAIL ovf_count: got %0d want 8", count); end
            end
            tick();
        end
        in_start = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (out_valid) begin
                checks++; if (out_idx !== 16'(n)) begin errors++; $display("FAIL drain_idx: got %0d want %0d", out_idx, n); end
                checks++; if (out_sym !== exp_sym(xv(132 + 10*n))) begin errors++; $display("FAIL drain_sym: got %h want %h", out_sym, exp_sym(xv(132 + 10*n))); end
                n++;
            end
            tick();
        end
        checks++; if (n != 8) begin errors++; $display("FAIL drain_count: got %0d want 8", n); end
        in_start = 1'b1;
        for (int c = 0; c < 150; c++) begin
            if (out_valid && first < 0) begin
                first = c;
                checks++; if (out_idx !== 16'd10) begin errors++; $display("FAIL ovf_gap_idx: got %0d want 10", out_idx); end
            end
            tick();
            in_start = 1'b0;
        end
        checks++; if (first != 133) begin errors++; $display("FAIL ovf_next_cycle: got %0d want 133", first); end
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b want 1", ovf); end
    endtask

    task automatic test_full_pop();
        int n = 0;
        do_reset();
        for (int c = 0; c < 240; c++) begin
            in_start = (c % 10 == 0) && (c < 90);
            out_ready = (c >= 212);
            X = xv(c);
            if (c == 211) begin
                checks++; if (count !== 4'd8) begin errors++; $display("FAIL fullpop_pre: got %0d want 8", count); end
            end
            if (c == 213) begin
                checks++; if (count !== 4'd8) begin errors++; $display("FAIL fullpop_count: got %0d want 8", count); end
                checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL fullpop_ovf: got %b want 0", ovf); end
            end
            if (out_valid && out_ready) begin
                checks++; if (out_idx !== 16'(n)) begin errors++; $display("FAIL fullpop_idx: got %0d want %0d", out_idx, n); end
                checks++; if (out_sym !== exp_sym(xv(132 + 10*n))) begin errors++; $display("FAIL fullpop_sym: got %h want %h", out_sym, exp_sym(xv(132 + 10*n))); end
                n++;
            end
            tick();
        end
        in_start = 1'b0;
        checks++; if (n != 9) begin errors++; $display("FAIL fullpop_words: got %0d want 9", n); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL fullpop_ovf_end: got %b want 0", ovf); end
    endtask

    task automatic test_reset_midflight();
        int bad = 0;
        int first = -1;
        do_reset();
        out_ready = 1'b1;
        in_start = 1'b1;
        for (int c = 0; c < 272; c++) begin
            rst = !(c == 70 || c == 71);
            if (out_valid || count != 0 || out_sym != 0 || out_idx != 0 || ovf) bad++;
            tick();
            in_start = 1'b0;
        end
        rst = 1'b1;
        checks++; if (bad != 0) begin errors++; $display("FAIL midrst_quiet: got %0d bad cycles want 0", bad); end
        in_start = 1'b1;
        for (int c = 0; c < 150; c++) begin
            if (out_valid && first < 0) begin
                first = c;
                checks++; if (out_idx !== 16'd0) begin errors++; $display("FAIL midrst_idx: got %0d want 0", out_idx); end
            end
            tick();
            in_start = 1'b0;
        end
        checks++; if (first != 133) begin errors++; $display("FAIL midrst_cycle: got %0d want 133", first); end
    endtask

    task automatic test_soft_clr();
        int stale = 0;
        int first = -1;
        do_reset();
        for (int c = 0; c < 320; c++) begin
            in_start = ((c % 10 == 0) && (c < 90)) || c == 150 || c == 160;
            out_ready = (c >= 213) && (c < 218);
            soft_clr = (c == 220);
            X = xv(c);
            if (c == 219) begin
                checks++; if (count !== 4'd3) begin errors++; $display("FAIL sclr_pre_count: got %0d want 3", count); end
                checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL sclr_pre_ovf: got %b want 1", ovf); end
            end
            if (c == 221) begin
                checks++; if (count !== 4'd0) begin errors++; $display("FAIL sclr_count: got %0d want 0", count); end
                checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL sclr_valid: got %b want 0", out_valid); end
                checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL sclr_ovf: got %b want 0", ovf); end
                checks++; if (out_sym !== 16'h0) begin errors++; $display("FAIL sclr_sym: got %h want 0000", out_sym); end
            end
            if (c > 221 && out_valid) stale++;
            tick();
        end
        soft_clr = 1'b0;
        checks++; if (stale != 0) begin errors++; $display("FAIL sclr_stale: got %0d want 0", stale); end
        out_ready = 1'b1;
        in_start = 1'b1;
        for (int c = 0; c < 150; c++) begin
            if (out_valid && first < 0) begin
                first = c;
                checks++; if (out_idx !== 16'd0) begin errors++; $display("FAIL sclr_idx: got %0d want 0", out_idx); end
            end
            tick();
            in_start = 1'b0;
        end
        checks++; if (first != 133) begin errors++; $display("FAIL sclr_next_cycle: got %0d want 133", first); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_stream();
        test_overflow();
        test_full_pop();
        test_reset_midflight();
        test_soft_clr();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mimo_out_collector.md
# mimo_out_collector

Output-side stage directly downstream of the 4x4 16QAM K-best detector top (`TopInterface`). It tracks each frame's fixed pipeline latency from its start pulse. It captures the 16-bit detected-symbol word `X` exactly when that frame's result is present, and buffers results in a small FIFO. A valid/ready interface delivers them, tagged with a frame index, to the host or bit-sink.

## Interface
Parameters:
- `LAT`, 132: cycles from frame start (first of the 10 input beats) to valid `X` for that frame; minimum 2.
- `DEPTH`, 8: FIFO entries; power of two, minimum 2.
- `IDXW`, 16: width of frame index tag.

Ports:
- `clk`  in  1: clock, rising edge.
- `rst`  in  1: reset; asynchronous, active-low.
- `soft_clr`  in  1: synchronous flush; same effect as reset, but taken on a clock edge.
- `in_start`  in  1: one-cycle pulse, coincident with the first input beat of a frame to the detector.
- `X`  in  16: detector output; symbol r is on `X[4r+3:4r]`; each nibble is {I[1:0], Q[1:0]} PAM index.
- `out_valid`  out  1: FIFO head valid.
- `out_ready`  in  1: consumer accepts head when high with `out_valid`.
- `out_sym`  out  16: head symbol word; mapping set by the Configuration section.
- `out_idx`  out  IDXW: capture index of head word.
- `count`  out  log2(DEPTH)+1: FIFO occupancy.
- `ovf`  out  1: sticky overflow flag.

## Operation
- Delay line: `LAT`-bit shift register. `in_start` enters at stage 0 and reaches stage `LAT-1` after `LAT-1` edges. A capture strobe fires when the last stage is high, so the capture samples the `X` present `LAT` cycles after the `in_start` cycle. Overlapping frames (period 10 < `LAT`) are handled naturally; any `in_start` spacing ≥1 is legal.
- Capture: on a strobe, the block forms word {`idx_cnt`, mapped `X`} and writes it into the FIFO.
  - `idx_cnt` increments on every capture, including dropped ones, so dropped frames appear as gaps in `out_idx`.
  - `idx_cnt` wraps modulo 2^IDXW.
- FIFO: read/write pointers of log2(DEPTH)+1 bits; empty when pointers are equal; full when they differ only in the MSB.
  - Pop when `out_valid & out_ready`.
- Boundary conditions:
  - Write when full, with no pop: word is dropped, `ovf` is set; the FIFO is unchanged.
  - Write when full, with a pop: both occur; `count` stays at `DEPTH`; `ovf` is not set.
  - Write when empty, with `out_ready` high: no bypass; the word appears on the next cycle.
  - `out_ready` with empty FIFO: ignored.
- `ovf` clears only on reset or `soft_clr`.
- `soft_clr` clears the delay line, the FIFO pointers, `idx_cnt` and `ovf`. In-flight frames are discarded. `soft_clr` has priority over a same-cycle capture or pop.

## Timing
- Reset values (async assert):
  - `out_valid`=0, `count`=0, `ovf`=0.
  - `out_sym`=0 and `out_idx`=0: head storage is registered and zero while empty.
  - Delay line and `idx_cnt` are all zero.
- Latency: `in_start` in cycle t → capture at edge ending cycle t+`LAT` → `out_valid` high in cycle t+`LAT`+1.
- `out_sym` and `out_idx` are stable while `out_valid` is high and `out_ready` is low.
- A pop at an edge presents the next entry, if any, in the following cycle.
- Throughput: one capture and one pop per cycle.
- Reset deasserted mid-stream: `in_start` pulses issued before reset are lost. The first capture occurs `LAT` cycles after the first post-reset `in_start`.

## Configuration
- `GRAY_DEMAP_EN` defined: each 2-bit PAM index p (I and Q per nibble) is mapped to Gray code {p[1], p[1]^p[0]}, i.e. 0→00, 1→01, 2→11, 3→10, before FIFO write.
- Not defined: `X` is written unchanged (raw symbol indices).
- The mapping is combinational in front of the FIFO write; latency is identical either way.

## Test plan
- Single frame, macro off: `in_start` at cycle 0, `X`=16'hA5C3 held through cycle 132, `out_ready`=1.
  - Required: `out_valid` in cycle 133 only, with `out_sym`=16'hA5C3 and `out_idx`=0.
  - Macro on: same stimulus gives `out_sym`=16'hF582.
- Streaming: 20 `in_start` pulses, 10 cycles apart, with distinct `X` per window and `out_ready`=1.
  - Required: 20 outputs, `out_idx` 0..19 in order, 10 cycles apart, matching `X`, `ovf`=0.
- Overflow (`DEPTH`=8): `out_ready`=0 and 10 frames.
  - Required: `count` saturates at 8 and `ovf`=1 after the 9th capture.
  - Then `out_ready`=1: exactly 8 words drain with `out_idx` 0..7; a following frame returns `out_idx`=10.
- Full with simultaneous pop: FIFO full, `out_ready`=1 on a capture edge.
  - Required: `count` stays 8, `ovf` stays 0, and the new word is last in order.
- Reset mid-flight: `in_start` at cycle 0, `rst` low during cycles 70–71.
  - Required: no `out_valid` for 200 cycles and all outputs 0.
  - Then a new `in_start` yields output `LAT`+1 cycles later with `out_idx`=0.
- `soft_clr`: with 3 words queued, `ovf`=1 and frames in flight, pulse `soft_clr`.
  - Required: next cycle `count`=0, `out_valid`=0, `ovf`=0, and no stale captures appear.
